// File: rtl/hazard_ctrl.sv
// hazard_ctrl: pipeline hazard controller.
// It detects load-use hazards, branch flushes and data-memory waits, drives the
// pipeline register enables and keeps saturating event counters.
// It also sets a sticky error flag when a memory wait runs too long.
module hazard_ctrl #(
    parameter int CNT_W      = 16,
    parameter int WAIT_LIMIT = 255
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             memread_ID_EX,
    input  logic [4:0]       rd_ID_EX,
    input  logic [4:0]       rs1_IF_ID,
    input  logic [4:0]       rs2_IF_ID,
    input  logic             uses_rs1,
    input  logic             uses_rs2,
    input  logic             branch_taken_EX,
    input  logic             mem_busy,
    output logic             pc_write,
    output logic             if_id_write,
    output logic             id_ex_hold,
    output logic             id_ex_bubble,
    output logic             if_id_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic [CNT_W-1:0] wait_cnt,
    output logic             wait_err
);

    // The run-length counter must be able to hold WAIT_LIMIT+1.
    localparam int RL_W = $clog2(WAIT_LIMIT + 2);
    localparam logic [RL_W-1:0]  RL_MAX   = RL_W'(WAIT_LIMIT + 1);
    localparam logic [RL_W-1:0]  RL_LIMIT = RL_W'(WAIT_LIMIT);
    localparam logic [CNT_W-1:0] CNT_MAX  = '1;

    typedef enum logic {
        ST_RUN  = 1'b0,
        ST_WAIT = 1'b1
    } state_t;

    state_t          state_reg;
    state_t          state_next;
    logic            lu;
    logic            do_stall;
    logic            do_flush;
    logic            enter_wait;
    logic [2:0]      cnt_inc;
    logic [CNT_W-1:0] cnt_reg [3];
    logic [RL_W-1:0] run_len_reg;
    logic [RL_W-1:0] run_len_next;
    logic            wait_err_reg;

    // Load-use hazard: a load in EX writes a register that the instruction in ID reads.
    // Register x0 never creates a dependency.
    assign lu = memread_ID_EX && (rd_ID_EX != 5'd0) &&
                ((uses_rs1 && (rs1_IF_ID == rd_ID_EX)) ||
                 (uses_rs2 && (rs2_IF_ID == rd_ID_EX)));

    // State register. An asynchronous reset always returns the FSM to RUN.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_reg <= ST_RUN;
        end else begin
            state_reg <= state_next;
        end
    end

    // Next state and pipeline controls.
    // Priority is mem_busy, then branch, then load-use.
    always_comb begin
        state_next   = state_reg;
        pc_write     = 1'b1;
        if_id_write  = 1'b1;
        id_ex_hold   = 1'b0;
        id_ex_bubble = 1'b0;
        if_id_flush  = 1'b0;
        do_stall     = 1'b0;
        do_flush     = 1'b0;
        enter_wait   = 1'b0;

        case (state_reg)
            ST_RUN:  if (mem_busy)  state_next = ST_WAIT;
            ST_WAIT: if (!mem_busy) state_next = ST_RUN;
            default: state_next = ST_RUN;
        endcase
        enter_wait = (state_reg == ST_RUN) && mem_busy;

        if (!reset) begin
            // While reset is held, keep the pipeline quiet and bubble ID/EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
        end else if (mem_busy) begin
            // Freeze the whole pipeline.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_hold   = 1'b1;
        end else if (branch_taken_EX) begin
            // Squash the wrong-path instructions in IF/ID and ID/EX.
            if_id_flush  = 1'b1;
            id_ex_bubble = 1'b1;
            do_flush     = 1'b1;
        end else if (lu) begin
            // Hold IF and ID for one cycle and insert a bubble into EX.
            pc_write     = 1'b0;
            if_id_write  = 1'b0;
            id_ex_bubble = 1'b1;
            do_stall     = 1'b1;
        end
    end

    // Index 0 is stalls, index 1 is flushes, index 2 is wait episodes.
    assign cnt_inc = {enter_wait, do_flush, do_stall};

    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_cnt
            // Saturating event counter. It stops at its maximum value and never wraps.
            always_ff @(posedge clk or negedge reset) begin
                if (!reset) begin
                    cnt_reg[gi] <= '0;
                end else if (cnt_inc[gi] && (cnt_reg[gi] != CNT_MAX)) begin
                    cnt_reg[gi] <= cnt_reg[gi] + 1'b1;
                end
            end
        end
    endgenerate

    assign stall_cnt = cnt_reg[0];
    assign flush_cnt = cnt_reg[1];
    assign wait_cnt  = cnt_reg[2];

    // Length of the current WAIT episode.
    // It counts clocks spent in WAIT, stops at WAIT_LIMIT+1, and is zero in RUN.
    always_comb begin
        run_len_next = '0;
        if (state_reg == ST_WAIT) begin
            run_len_next = (run_len_reg == RL_MAX) ? run_len_reg : run_len_reg + 1'b1;
        end
    end

    // Run-length register and sticky timeout flag. Only reset clears the flag.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            run_len_reg  <= '0;
            wait_err_reg <= 1'b0;
        end else begin
            run_len_reg  <= run_len_next;
            wait_err_reg <= wait_err_reg || (run_len_next > RL_LIMIT);
        end
    end

    assign wait_err = wait_err_reg;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb_hazard_ctrl: directed and randomized checks of hazard_ctrl.
// The expected values come from a behavioural reference model.
module tb_hazard_ctrl;

    localparam int CNT_W      = 2;
    localparam int WAIT_LIMIT = 4;
    localparam int CMAX       = (1 << CNT_W) - 1;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             memread_ID_EX = 1'b0;
    logic [4:0]       rd_ID_EX = '0;
    logic [4:0]       rs1_IF_ID = '0;
    logic [4:0]       rs2_IF_ID = '0;
    logic             uses_rs1 = 1'b0;
    logic             uses_rs2 = 1'b0;
    logic             branch_taken_EX = 1'b0;
    logic             mem_busy = 1'b0;
    logic             pc_write;
    logic             if_id_write;
    logic             id_ex_hold;
    logic             id_ex_bubble;
    logic             if_id_flush;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;
    logic [CNT_W-1:0] wait_cnt;
    logic             wait_err;

    hazard_ctrl #(
        .CNT_W      (CNT_W),
        .WAIT_LIMIT (WAIT_LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .memread_ID_EX   (memread_ID_EX),
        .rd_ID_EX        (rd_ID_EX),
        .rs1_IF_ID       (rs1_IF_ID),
        .rs2_IF_ID       (rs2_IF_ID),
        .uses_rs1        (uses_rs1),
        .uses_rs2        (uses_rs2),
        .branch_taken_EX (branch_taken_EX),
        .mem_busy        (mem_busy),
        .pc_write        (pc_write),
        .if_id_write     (if_id_write),
        .id_ex_hold      (id_ex_hold),
        .id_ex_bubble    (id_ex_bubble),
        .if_id_flush     (if_id_flush),
        .stall_cnt       (stall_cnt),
        .flush_cnt       (flush_cnt),
        .wait_cnt        (wait_cnt),
        .wait_err        (wait_err)
    );

    always #5 clk = ~clk;

    int compared   = 0;
    int mismatched = 0;

    // Reference model state.
    int m_stall, m_flush, m_wait, m_run;
    bit m_waiting;
    bit m_err;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        compared++;
        assert (obs === exp) else begin
            mismatched++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    function automatic bit lu_now();
        return memread_ID_EX && (rd_ID_EX != 0) &&
               ((uses_rs1 && rs1_IF_ID == rd_ID_EX) || (uses_rs2 && rs2_IF_ID == rd_ID_EX));
    endfunction

    function automatic int sat_inc(input int v);
        return (v < CMAX) ? v + 1 : v;
    endfunction

    task automatic model_reset();
        m_stall = 0; m_flush = 0; m_wait = 0; m_run = 0;
        m_waiting = 1'b0; m_err = 1'b0;
    endtask

    // One rising edge of the model, with reset high.
    // Waiting means that mem_busy was high at the previous edge.
    task automatic model_edge();
        if (mem_busy && !m_waiting) m_wait = sat_inc(m_wait);
        if (!mem_busy && branch_taken_EX) m_flush = sat_inc(m_flush);
        else if (!mem_busy && lu_now()) m_stall = sat_inc(m_stall);
        if (m_waiting) m_run = (m_run < WAIT_LIMIT + 1) ? m_run + 1 : m_run;
        else m_run = 0;
        if (m_run > WAIT_LIMIT) m_err = 1'b1;
        m_waiting = mem_busy;
    endtask

    task automatic check_all();
        logic [4:0] e;   // {pc_write, if_id_write, id_ex_hold, id_ex_bubble, if_id_flush}
        if (!reset)               e = 5'b00010;
        else if (mem_busy)        e = 5'b00100;
        else if (branch_taken_EX) e = 5'b11011;
        else if (lu_now())        e = 5'b00010;
        else                      e = 5'b11000;
        check("pc_write",     32'(pc_write),     32'(e[4]));
        check("if_id_write",  32'(if_id_write),  32'(e[3]));
        check("id_ex_hold",   32'(id_ex_hold),   32'(e[2]));
        check("id_ex_bubble", 32'(id_ex_bubble), 32'(e[1]));
        check("if_id_flush",  32'(if_id_flush),  32'(e[0]));
        check("stall_cnt",    32'(stall_cnt),    32'(m_stall));
        check("flush_cnt",    32'(flush_cnt),    32'(m_flush));
        check("wait_cnt",     32'(wait_cnt),     32'(m_wait));
        check("wait_err",     32'(wait_err),     32'(m_err));
    endtask

    // Called at posedge+1. It drives the inputs, checks them at the negedge, and advances one edge.
    task automatic step(input logic mb, input logic br, input logic mr, input logic [4:0] rd,
                        input logic [4:0] r1, input logic [4:0] r2, input logic u1, input logic u2);
        mem_busy = mb; branch_taken_EX = br; memread_ID_EX = mr; rd_ID_EX = rd;
        rs1_IF_ID = r1; rs2_IF_ID = r2; uses_rs1 = u1; uses_rs2 = u2;
        @(negedge clk);
        check_all();
        @(posedge clk);
        model_edge();
        #1;
    endtask

    // Called at posedge+1. It asserts reset asynchronously and holds it for one clock.
    task automatic pulse_reset();
        reset = 1'b0;
        model_reset();
        #1;
        check_all();
        @(negedge clk);
        check_all();
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    initial begin
        model_reset();
        // The reset state must hold regardless of the hazard inputs.
        mem_busy = 1'b1; branch_taken_EX = 1'b1; memread_ID_EX = 1'b1;
        rd_ID_EX = 5'd5; rs1_IF_ID = 5'd5; uses_rs1 = 1'b1;
        repeat (2) begin
            @(negedge clk);
            check_all();
        end
        @(posedge clk);
        #1;
        reset = 1'b1;
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Load-use stall on rs1.
        step(0, 0, 1, 5, 5, 0, 1, 0);
        check("lu_stall_cnt", 32'(stall_cnt), 32'd1);
        // A destination of x0 never stalls.
        step(0, 0, 1, 0, 0, 0, 1, 0);
        check("x0_stall_cnt", 32'(stall_cnt), 32'd1);
        // Branch and load-use together: the flush wins.
        step(0, 1, 1, 5, 5, 0, 1, 0);
        check("br_lu_flush", 32'(flush_cnt), 32'd1);
        check("br_lu_stall", 32'(stall_cnt), 32'd1);

        // Freeze with a pending branch, then the branch flush.
        pulse_reset();
        repeat (3) step(1, 1, 0, 0, 0, 0, 0, 0);
        check("freeze_wait_cnt",  32'(wait_cnt),  32'd1);
        check("freeze_flush_cnt", 32'(flush_cnt), 32'd0);
        step(0, 1, 0, 0, 0, 0, 0, 0);
        check("unfreeze_flush", 32'(flush_cnt), 32'd1);

        // Wait timeout.
        pulse_reset();
        repeat (5) step(1, 0, 0, 0, 0, 0, 0, 0);
        check("err_before_limit", 32'(wait_err), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("err_at_limit", 32'(wait_err), 32'd1);
        repeat (3) step(0, 0, 0, 0, 0, 0, 0, 0);
        check("err_sticky", 32'(wait_err), 32'd1);
        pulse_reset();
        check("err_cleared", 32'(wait_err), 32'd0);

        // Counter saturation, then a reset in the middle of a WAIT.
        repeat (5) step(0, 0, 1, 7, 0, 7, 0, 1);
        check("stall_saturated", 32'(stall_cnt), 32'(CMAX));
        repeat (2) step(1, 0, 0, 0, 0, 0, 0, 0);
        pulse_reset();
        check("mid_wait_reset_stall", 32'(stall_cnt), 32'd0);
        step(1, 0, 0, 0, 0, 0, 0, 0);
        check("run_after_reset", 32'(wait_cnt), 32'd1);
        step(0, 0, 0, 0, 0, 0, 0, 0);

        // Randomized traffic with bursty mem_busy and occasional resets.
        begin
            int busy_left = 0;
            for (int i = 0; i < 800; i++) begin
                logic mb;
                if ($urandom_range(0, 59) == 0) pulse_reset();
                if (busy_left > 0) begin
                    mb = 1'b1;
                    busy_left--;
                end else if ($urandom_range(0, 5) == 0) begin
                    mb = 1'b1;
                    busy_left = $urandom_range(0, 7);
                end else begin
                    mb = 1'b0;
                end
                step(mb, ($urandom_range(0, 4) == 0), 1'($urandom), 5'($urandom_range(0, 3)),
                     5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom), 1'($urandom));
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
